// File: rtl/fifo_rd_sched.sv
// Round-robin burst read scheduler draining several async_fifo read ports
// into a single valid/ready output stream, one word in flight at a time.
module fifo_rd_sched #(
  parameter int NUM_CH   = 4,
  parameter int DATESIZE = 8,
  parameter int CHW      = 2,
  parameter int BURST    = 4
) (
  input  logic                         rclk,
  input  logic                         r_rstn,
  input  logic [NUM_CH-1:0]            ch_rempty,
  input  logic [NUM_CH*DATESIZE-1:0]   ch_rdata,
  input  logic [NUM_CH-1:0]            ch_en,
  output logic [NUM_CH-1:0]            ch_rinc,
  output logic [DATESIZE-1:0]          dout,
  output logic [CHW-1:0]               dout_ch,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t                state_r;
  logic [CHW-1:0]        gnt_r;
  logic [CHW-1:0]        rr_ptr_r;
  logic [7:0]            burst_cnt_r;
  logic [NUM_CH-1:0]     ch_rinc_r;
  logic [DATESIZE-1:0]   dout_r;
  logic [CHW-1:0]        dout_ch_r;
  logic                  dout_valid_r;
  logic                  busy_r;

  logic [NUM_CH-1:0]     elig_s;
  logic                  pick_found_s;
  logic [CHW-1:0]        pick_idx_s;
  logic [CHW-1:0]        gnt_next_s;
  logic [DATESIZE-1:0]   rdata_sel_s;
  logic                  gnt_elig_s;
  logic                  burst_more_s;

  function automatic logic [NUM_CH-1:0] onehot_f(input logic [CHW-1:0] idx);
    logic [NUM_CH-1:0] v;
    v      = {NUM_CH{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  assign elig_s       = ch_en & ~ch_rempty;
  assign gnt_elig_s   = elig_s[gnt_r];
  assign burst_more_s = (burst_cnt_r < 8'(BURST));
  assign gnt_next_s   = (gnt_r == CHW'(NUM_CH - 1)) ? {CHW{1'b0}} : (gnt_r + CHW'(1));

  // First eligible channel at or after rr_ptr, wrapping modulo NUM_CH
  always_comb begin
    logic [CHW:0] sum_v;
    sum_v        = {(CHW+1){1'b0}};
    pick_found_s = 1'b0;
    pick_idx_s   = {CHW{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      sum_v = {1'b0, rr_ptr_r} + (CHW+1)'(k);
      if (sum_v >= (CHW+1)'(NUM_CH)) begin
        sum_v = sum_v - (CHW+1)'(NUM_CH);
      end else begin
        sum_v = sum_v;
      end
      if (!pick_found_s && elig_s[sum_v[CHW-1:0]]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = sum_v[CHW-1:0];
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Read-data lane of the granted channel
  always_comb begin
    rdata_sel_s = {DATESIZE{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_r == CHW'(i)) begin
        rdata_sel_s = ch_rdata[i*DATESIZE +: DATESIZE];
      end else begin
        rdata_sel_s = rdata_sel_s;
      end
    end
  end

  // Scheduler FSM; every output is a register loaded on the transition
  always_ff @(posedge rclk or negedge r_rstn) begin
    if (!r_rstn) begin
      state_r      <= IDLE;
      gnt_r        <= {CHW{1'b0}};
      rr_ptr_r     <= {CHW{1'b0}};
      burst_cnt_r  <= 8'd0;
      ch_rinc_r    <= {NUM_CH{1'b0}};
      dout_r       <= {DATESIZE{1'b0}};
      dout_ch_r    <= {CHW{1'b0}};
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_found_s) begin
            state_r     <= READ;
            gnt_r       <= pick_idx_s;
            burst_cnt_r <= 8'd0;
            ch_rinc_r   <= onehot_f(pick_idx_s);
            busy_r      <= 1'b1;
          end else begin
            state_r     <= IDLE;
            ch_rinc_r   <= {NUM_CH{1'b0}};
            busy_r      <= 1'b0;
          end
        end
        READ: begin
          state_r   <= CAPT;
          ch_rinc_r <= {NUM_CH{1'b0}};
          busy_r    <= 1'b1;
        end
        CAPT: begin
          state_r      <= WAIT;
          dout_r       <= rdata_sel_s;
          dout_ch_r    <= gnt_r;
          dout_valid_r <= 1'b1;
          burst_cnt_r  <= burst_cnt_r + 8'd1;
          ch_rinc_r    <= {NUM_CH{1'b0}};
          busy_r       <= 1'b1;
        end
        WAIT: begin
          if (dout_ready) begin
            dout_valid_r <= 1'b0;
            // rempty is only trusted here, two cycles after the last read strobe
            if (burst_more_s && gnt_elig_s) begin
              state_r   <= READ;
              ch_rinc_r <= onehot_f(gnt_r);
              busy_r    <= 1'b1;
            end else begin
              state_r   <= IDLE;
              rr_ptr_r  <= gnt_next_s;
              ch_rinc_r <= {NUM_CH{1'b0}};
              busy_r    <= 1'b0;
            end
          end else begin
            state_r   <= WAIT;
            ch_rinc_r <= {NUM_CH{1'b0}};
            busy_r    <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          ch_rinc_r    <= {NUM_CH{1'b0}};
          dout_valid_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign ch_rinc    = ch_rinc_r;
  assign dout       = dout_r;
  assign dout_ch    = dout_ch_r;
  assign dout_valid = dout_valid_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Scoreboard bench for fifo_rd_sched with behavioural FIFO models on each channel.
module tb_fifo_rd_sched;

  logic        rclk = 1'b0;
  logic        r_rstn;
  logic [3:0]  ch_rempty = 4'hF;
  logic [31:0] ch_rdata;
  logic [3:0]  ch_en;
  logic [3:0]  ch_rinc;
  logic [7:0]  dout;
  logic [1:0]  dout_ch;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;

  logic [7:0]  fq [4][$];
  logic [7:0]  rdata_r [4];
  logic [7:0]  exp_data [$];
  logic [1:0]  exp_ch [$];
  int          rinc_cnt [4];
  int          checks = 0;
  int          failures = 0;

  fifo_rd_sched #(.NUM_CH(4), .DATESIZE(8), .CHW(2), .BURST(4)) dut (
    .rclk(rclk), .r_rstn(r_rstn), .ch_rempty(ch_rempty), .ch_rdata(ch_rdata),
    .ch_en(ch_en), .ch_rinc(ch_rinc), .dout(dout), .dout_ch(dout_ch),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy)
  );

  always #5 rclk = ~rclk;

  assign ch_rdata = {rdata_r[3], rdata_r[2], rdata_r[1], rdata_r[0]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // FIFO models: data valid the cycle after rinc, rempty registered
  initial for (int i = 0; i < 4; i++) rdata_r[i] = 8'h00;
  always @(posedge rclk) begin
    for (int i = 0; i < 4; i++) begin
      int sz;
      sz = fq[i].size();
      if (ch_rinc[i]) begin
        chk("read_nonempty", (sz > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sz > 0) begin
          rdata_r[i] <= fq[i].pop_front();
          sz = sz - 1;
        end
      end
      ch_rempty[i] <= (sz == 0);
    end
  end

  // Monitor: strobe legality and scoreboard compare on each handshake
  always @(negedge rclk) begin
    if (r_rstn) begin
      if (ch_rinc != 4'b0000) begin
        chk("rinc_onehot", {31'd0, $onehot(ch_rinc)}, 32'd1);
        for (int i = 0; i < 4; i++) if (ch_rinc[i]) rinc_cnt[i]++;
      end
      if (dout_valid && dout_ready) begin
        if (exp_data.size() == 0) begin
          chk("unexpected_word", {22'd0, dout_ch, dout}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_ch", {30'd0, dout_ch}, {30'd0, exp_ch.pop_front()});
          chk("sb_data", {24'd0, dout}, {24'd0, exp_data.pop_front()});
        end
      end
    end
  end

  task automatic expect_word(input logic [1:0] c, input logic [7:0] d);
    exp_ch.push_back(c);
    exp_data.push_back(d);
  endtask

  task automatic do_reset();
    r_rstn = 1'b0;
    ch_en = 4'hF;
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fq[i].delete();
      rinc_cnt[i] = 0;
    end
    repeat (3) @(posedge rclk);
    #1;
    chk("rst_rinc", {28'd0, ch_rinc}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_dout_ch", {30'd0, dout_ch}, 32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge rclk);
    r_rstn = 1'b1;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_data.size() != 0 || busy) && n < max_cyc) begin
      @(posedge rclk);
      n++;
    end
    chk("drain_timeout", (n < max_cyc) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) @(posedge rclk);
  endtask

  task automatic wait_rinc(input int ch, input string nm);
    int n;
    n = 0;
    while (!ch_rinc[ch] && n < 50) begin
      @(negedge rclk);
      n++;
    end
    chk(nm, {31'd0, ch_rinc[ch]}, 32'd1);
  endtask

  initial begin
    logic [7:0] hold_d;
    logic [1:0] hold_c;
    int n;

    // Single channel, two words: latency and no extra read
    do_reset();
    @(negedge rclk);
    fq[0].push_back(8'hA0);
    fq[0].push_back(8'hA1);
    expect_word(2'd0, 8'hA0);
    expect_word(2'd0, 8'hA1);
    @(posedge rclk); #1;
    chk("t1_eligible", {31'd0, ch_rempty[0]}, 32'd0);
    @(posedge rclk); #1;
    chk("t1_rinc_t1", {28'd0, ch_rinc}, 32'h1);
    @(posedge rclk); #1;
    chk("t1_valid_t2", {31'd0, dout_valid}, 32'd0);
    @(posedge rclk); #1;
    chk("t1_valid_t3", {31'd0, dout_valid}, 32'd1);
    drain(100);
    chk("t1_rinc_ch0", rinc_cnt[0], 32'd2);
    chk("t1_rinc_other", rinc_cnt[1] + rinc_cnt[2] + rinc_cnt[3], 32'd0);

    // All channels full: bursts of four in round-robin order
    do_reset();
    @(negedge rclk);
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 10; j++) fq[c].push_back(8'((c << 4) | j));
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        for (int j = r * 4; j < r * 4 + 4 && j < 10; j++)
          expect_word(2'(c), 8'((c << 4) | j));
    drain(1000);
    for (int c = 0; c < 4; c++) chk("t2_rinc_cnt", rinc_cnt[c], 32'd10);

    // Backpressure: output held stable while dout_ready is low
    do_reset();
    dout_ready = 1'b0;
    @(negedge rclk);
    fq[2].push_back(8'h5A);
    expect_word(2'd2, 8'h5A);
    n = 0;
    while (!dout_valid && n < 20) begin
      @(negedge rclk);
      n++;
    end
    chk("t3_valid_seen", {31'd0, dout_valid}, 32'd1);
    hold_d = dout;
    hold_c = dout_ch;
    repeat (5) begin
      @(negedge rclk);
      chk("t3_stall_dout", {24'd0, dout}, {24'd0, hold_d});
      chk("t3_stall_ch", {30'd0, dout_ch}, {30'd0, hold_c});
      chk("t3_stall_valid", {31'd0, dout_valid}, 32'd1);
      chk("t3_stall_rinc", {28'd0, ch_rinc}, 32'd0);
    end
    @(posedge rclk); #1;
    dout_ready = 1'b1;
    drain(100);

    // ch_en dropped during ch1's read: word delivered, grant moves on
    do_reset();
    @(negedge rclk);
    for (int j = 0; j < 5; j++) fq[1].push_back(8'(8'h10 + j));
    fq[2].push_back(8'h20);
    fq[2].push_back(8'h21);
    expect_word(2'd1, 8'h10);
    expect_word(2'd2, 8'h20);
    expect_word(2'd2, 8'h21);
    wait_rinc(1, "t4_ch1_read");
    ch_en[1] = 1'b0;
    drain(200);
    chk("t4_rinc_ch1", rinc_cnt[1], 32'd1);
    chk("t4_rinc_ch2", rinc_cnt[2], 32'd2);

    // Reset during CAPT: in-flight word discarded, arbitration restarts at 0
    do_reset();
    @(negedge rclk);
    fq[2].push_back(8'h20);
    fq[2].push_back(8'h21);
    wait_rinc(2, "t5_ch2_read");
    @(negedge rclk);
    chk("t5_busy_capt", {31'd0, busy}, 32'd1);
    r_rstn = 1'b0;
    #1;
    chk("t5_rst_rinc", {28'd0, ch_rinc}, 32'd0);
    chk("t5_rst_dout", {24'd0, dout}, 32'd0);
    chk("t5_rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    fq[1].push_back(8'h10);
    expect_word(2'd1, 8'h10);
    expect_word(2'd2, 8'h21);
    repeat (2) @(negedge rclk);
    r_rstn = 1'b1;
    drain(200);

    // Nothing enabled: block stays idle despite data everywhere
    do_reset();
    ch_en = 4'h0;
    @(negedge rclk);
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 3; j++) fq[c].push_back(8'(j));
    repeat (20) begin
      @(negedge rclk);
      chk("t6_idle", {26'd0, ch_rinc, busy, dout_valid}, 32'd0);
    end
    chk("t6_sb_empty", exp_data.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_rd_sched.md
FIFO_RD_SCHED -- requirements
Module: fifo_rd_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter NUM_CH, default 4, the number of async_fifo read ports served.
REQ-002 The block SHALL have parameter DATESIZE, default 8, the FIFO word width.
REQ-003 The block SHALL have parameter CHW, default 2, the channel index width (log2 of NUM_CH).
REQ-004 The block SHALL have parameter BURST, default 4, the maximum words read from one channel per grant (range 1..255).

Ports:
REQ-005 The block SHALL have port rclk, input, 1, the sole clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port r_rstn, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port ch_rempty, input, NUM_CH, the registered rempty flags of the FIFOs.
REQ-008 The block SHALL have port ch_rdata, input, NUM_CH*DATESIZE, FIFO read data; channel i occupies bits [i*DATESIZE +: DATESIZE] and is valid one cycle after its rinc.
REQ-009 The block SHALL have port ch_en, input, NUM_CH, the per-channel service enable mask (configuration).
REQ-010 The block SHALL have port ch_rinc, output, NUM_CH, the per-channel read strobes (one-hot or zero).
REQ-011 The block SHALL have port dout, output, DATESIZE, the delivered word.
REQ-012 The block SHALL have port dout_ch, output, CHW, the source channel of dout.
REQ-013 The block SHALL have port dout_valid, output, 1, which is high when dout/dout_ch hold an undelivered word.
REQ-014 The block SHALL have port dout_ready, input, 1, the downstream accept signal.
REQ-015 The block SHALL have port busy, output, 1, which is high whenever the state is not IDLE.

Function
REQ-016 Channel i SHALL be eligible iff ch_en[i]=1 and ch_rempty[i]=0.
REQ-017 The FSM SHALL have exactly four states: IDLE, READ, CAPT and WAIT.
REQ-018 In IDLE with any channel eligible, the block SHALL grant the first eligible channel searching upward from rr_ptr with wrap-around, clear burst_cnt, and go to READ; otherwise it SHALL stay in IDLE.
REQ-019 In READ, ch_rinc[gnt] SHALL be 1 for exactly this one cycle, all other ch_rinc bits SHALL be 0, and the next state SHALL be CAPT.
REQ-020 In CAPT, at the clock edge the block SHALL load dout<=ch_rdata[gnt], dout_ch<=gnt and dout_valid<=1, increment burst_cnt, and go to WAIT.
REQ-021 In WAIT, dout, dout_ch and dout_valid SHALL be held stable while dout_ready=0.
REQ-022 When WAIT sees dout_ready=1, the block SHALL clear dout_valid at that edge.
REQ-023 On that dout_ready=1 handshake, if burst_cnt<BURST and gnt is still eligible, the next state SHALL be READ on the same channel.
REQ-024 Otherwise, on that handshake, rr_ptr SHALL become (gnt+1) mod NUM_CH and the next state SHALL be IDLE.
REQ-025 ch_rinc SHALL be 0 in IDLE, CAPT and WAIT; at most one read SHALL ever be in flight.
REQ-026 Latency SHALL be: eligible in IDLE at cycle t -> rinc at t+1 -> dout_valid=1 at t+3; in-burst, handshake at u -> next dout_valid=1 at u+3; throughput SHALL be at most 1 word per 3 cycles.
REQ-027 ch_rempty SHALL be sampled only in IDLE and on the WAIT handshake, at least 2 cycles after the last rinc, so its one-cycle update lag never causes an extra read of an empty FIFO.
REQ-028 ch_en deasserted for gnt mid-burst SHALL NOT abort the in-flight word: the word SHALL be delivered, then the burst SHALL end per REQ-024.
REQ-029 When rr_ptr points to a non-eligible channel, the search SHALL skip it; when NUM_CH-1 is granted, rr_ptr SHALL wrap to 0.
REQ-030 ch_en all zero SHALL hold the block in IDLE with no rinc.
REQ-031 burst_cnt SHALL be 8 bits and SHALL never exceed BURST.

Reset
REQ-032 While r_rstn=0, the block SHALL force state=IDLE, ch_rinc=0, dout=0, dout_ch=0, dout_valid=0, busy=0, rr_ptr=0 and burst_cnt=0, asynchronously.
REQ-033 On reset mid-operation, a word already read from a FIFO but not yet handshaken SHALL be discarded.
REQ-034 After reset release, arbitration SHALL start from channel 0.

Verification
REQ-035 Reset, ch_en=4'hF, ch_rempty[0] only low, FIFO0 holding 2 words, dout_ready=1 -> ch_rinc=4'b0001 pulses twice, dout_ch=0 both times, first dout_valid 3 cycles after eligibility, no third rinc.
REQ-036 All 4 channels holding 10 words each, BURST=4, dout_ready=1 -> ch 0,0,0,0,1,1,1,1,2,2,2,2,3,... order, 4 words per grant.
REQ-037 dout_ready=0 for 5 cycles in WAIT -> dout and dout_ch stable, dout_valid=1 throughout, ch_rinc=0 throughout.
REQ-038 ch_en[1] cleared during ch1's READ cycle -> that word is delivered with dout_ch=1, then the grant moves to ch2, and ch1 receives no further rinc.
REQ-039 r_rstn pulsed low during CAPT -> all outputs 0 immediately, busy=0, and the first post-reset grant goes to the lowest eligible channel at or above 0.
REQ-040 ch_en=4'h0 with all FIFOs non-empty for 20 cycles -> ch_rinc=0, busy=0 and dout_valid=0 throughout.
